// File: rtl/regwrite_arbiter.sv
// Shares the register-file write port between load and ALU writeback sources. Load has priority; ALU wins after MAX_WAIT lost contests.
// Latency 1 to RegWrite; no output backpressure. A source is stalled only by losing arbitration.
module regwrite_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_reg,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_reg,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_reg,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic [31:0]       busy,
   output logic              conflict
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   logic [3:0]        wait_cnt;
   logic [3:0]        wait_nxt;
   logic              xfer;
   logic [ADDR_W-1:0] xfer_reg;
   logic [DATA_W-1:0] xfer_data;
   logic [31:0]       busy_nxt;
   logic              conflict_nxt;

   // Readies are forced low during reset so nothing is accepted while state is cleared.
   always_comb begin
      alu_ready = reset_n && alu_valid && (!mem_valid || wait_cnt == WAIT_LIMIT);
      mem_ready = reset_n && mem_valid && !alu_ready;
      xfer      = alu_ready || mem_ready;
      xfer_reg  = alu_ready ? alu_reg  : mem_reg;
      xfer_data = alu_ready ? alu_data : mem_data;
   end

   always_comb begin
      wait_nxt = wait_cnt;
      if (!alu_valid || alu_ready)
         wait_nxt = 4'd0;
      else if (wait_cnt < WAIT_LIMIT)
         wait_nxt = wait_cnt + 4'd1;
   end

   // A same-cycle reservation overrides the clear: the new producer owns the register.
   always_comb begin
      busy_nxt = busy;
      if (xfer)
         busy_nxt[xfer_reg] = 1'b0;
      if (rsv_valid && rsv_reg != '0)
         busy_nxt[rsv_reg] = 1'b1;
      busy_nxt[0] = 1'b0;
      conflict_nxt = rsv_valid && (rsv_reg != '0) && busy[rsv_reg]
                     && !(xfer && xfer_reg == rsv_reg);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt      <= 4'd0;
         RegWrite      <= 1'b0;
         WriteRegister <= '0;
         WriteData     <= '0;
         busy          <= '0;
         conflict      <= 1'b0;
      end else begin
         wait_cnt <= wait_nxt;
         busy     <= busy_nxt;
         conflict <= conflict_nxt;
         RegWrite <= xfer && (xfer_reg != '0);
         if (xfer) begin
            WriteRegister <= xfer_reg;
            WriteData     <= xfer_data;
         end
      end
   end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Randomized and directed bench for regwrite_arbiter against a behavioural model.
module tb_regwrite_arbiter;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              alu_valid, mem_valid, rsv_valid;
   logic              alu_ready, mem_ready;
   logic [ADDR_W-1:0] alu_reg, mem_reg, rsv_reg;
   logic [DATA_W-1:0] alu_data, mem_data;
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteRegister;
   logic [DATA_W-1:0] WriteData;
   logic [31:0]       busy;
   logic              conflict;

   always #5 clk = ~clk;

   regwrite_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
      .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .busy(busy), .conflict(conflict)
   );

   int checks = 0;
   int failures = 0;

   // Reference model state: a set of reserved registers and a count of contests lost.
   bit          m_busy[32];
   int          m_lost;
   bit          m_we;
   int          m_wreg;
   logic [31:0] m_wdata;
   bit          m_conf;
   bit          last_alu_rdy, last_mem_rdy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_lost = 0; m_we = 0; m_wreg = 0; m_wdata = '0; m_conf = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".RegWrite"}, RegWrite, m_we);
      check({tag, ".WriteRegister"}, WriteRegister, m_wreg[4:0]);
      check({tag, ".WriteData"}, WriteData, m_wdata);
      check({tag, ".busy"}, busy, model_busy());
      check({tag, ".conflict"}, conflict, m_conf);
   endtask

   // One clock: drive at negedge, check readies, clock, advance model, check outputs.
   task automatic cycle(input bit av, input int ar, input logic [31:0] ad,
                        input bit mv, input int mr, input logic [31:0] md,
                        input bit rv, input int rr, output bit ga, output bit gm);
      bit          xf;
      int          xr;
      logic [31:0] xd;
      alu_valid = av; alu_reg = 5'(ar); alu_data = ad;
      mem_valid = mv; mem_reg = 5'(mr); mem_data = md;
      rsv_valid = rv; rsv_reg = 5'(rr);
      #1;
      ga = av && (!mv || m_lost == MAX_WAIT);
      gm = mv && !ga;
      last_alu_rdy = alu_ready;
      last_mem_rdy = mem_ready;
      check("alu_ready", alu_ready, ga);
      check("mem_ready", mem_ready, gm);
      xf = ga || gm;
      xr = ga ? ar : mr;
      xd = ga ? ad : md;
      @(posedge clk);
      m_conf = rv && rr != 0 && m_busy[rr] && !(xf && xr == rr);
      if (xf) m_busy[xr] = 1'b0;
      if (rv && rr != 0) m_busy[rr] = 1'b1;
      if (!av || ga) m_lost = 0;
      else if (m_lost < MAX_WAIT) m_lost++;
      m_we = xf && xr != 0;
      if (xf) begin m_wreg = xr; m_wdata = xd; end
      @(negedge clk);
      check_outputs("cyc");
   endtask

   initial begin
      bit ga, gm;
      bit a_p, m_p;
      int a_r, m_r;
      logic [31:0] a_d, m_d;

      reset_n = 1'b0;
      alu_valid = 1'b1; mem_valid = 1'b1; rsv_valid = 1'b0;
      alu_reg = '0; mem_reg = '0; rsv_reg = '0; alu_data = '0; mem_data = '0;
      model_reset();
      #12;
      check("rst.alu_ready", alu_ready, 1'b0);
      check("rst.mem_ready", mem_ready, 1'b0);
      check_outputs("rst");
      @(negedge clk);
      reset_n = 1'b1;

      // Single ALU write.
      cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, ga, gm);
      check("t1.ready", last_alu_rdy, 1'b1);
      check("t1.RegWrite", RegWrite, 1'b1);
      check("t1.WriteData", WriteData, 32'hDEADBEEF);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
      check("t1.RegWrite_off", RegWrite, 1'b0);

      // Both sources contend: load wins four times, then the ALU once.
      for (int i = 0; i < 6; i++) begin
         cycle(1, 3, 32'hA0 + i, 1, 4, 32'hB0 + i, 0, 0, ga, gm);
         check("t2.alu_grant", last_alu_rdy, (i == 4));
         check("t2.mem_grant", last_mem_rdy, (i != 4));
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);

      // Load to r0 handshakes but never strobes.
      cycle(0, 0, 0, 1, 0, 32'h1234, 0, 0, ga, gm);
      check("t3.ready", last_mem_rdy, 1'b1);
      check("t3.RegWrite", RegWrite, 1'b0);
      check("t3.busy", busy, 32'h0);

      // Reserve/clear, and same-cycle reserve beats clear.
      cycle(0, 0, 0, 0, 0, 0, 1, 7, ga, gm);
      check("t4.busy7", busy[7], 1'b1);
      cycle(0, 0, 0, 1, 7, 32'h77, 0, 0, ga, gm);
      check("t4.busy7_clr", busy[7], 1'b0);
      cycle(1, 9, 32'h99, 0, 0, 0, 1, 9, ga, gm);
      check("t4.busy9", busy[9], 1'b1);
      cycle(1, 9, 32'h9A, 0, 0, 0, 0, 0, ga, gm);

      // Double reservation pulses conflict once.
      cycle(0, 0, 0, 0, 0, 0, 1, 7, ga, gm);
      check("t5.conf0", conflict, 1'b0);
      cycle(0, 0, 0, 0, 0, 0, 1, 7, ga, gm);
      check("t5.conf1", conflict, 1'b1);
      check("t5.busy7", busy[7], 1'b1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
      check("t5.conf2", conflict, 1'b0);

      // Asynchronous reset while a write is on the port.
      cycle(1, 3, 32'h33, 0, 0, 0, 0, 0, ga, gm);
      check("t6.pre_RegWrite", RegWrite, 1'b1);
      check("t6.pre_busy", busy, 32'h80);
      #2;
      reset_n = 1'b0;
      alu_valid = 1'b1; mem_valid = 1'b1;
      #1;
      check("t6.RegWrite", RegWrite, 1'b0);
      check("t6.busy", busy, 32'h0);
      check("t6.conflict", conflict, 1'b0);
      model_reset();
      repeat (2) begin
         @(posedge clk); #1;
         check("t6.alu_ready", alu_ready, 1'b0);
         check("t6.mem_ready", mem_ready, 1'b0);
      end
      @(negedge clk);
      check_outputs("t6.hold");
      reset_n = 1'b1;

      // Random traffic over a small register window to provoke collisions.
      a_p = 0; m_p = 0; a_r = 0; m_r = 0; a_d = '0; m_d = '0;
      for (int n = 0; n < 600; n++) begin
         if (!a_p && ($urandom % 3 != 0)) begin
            a_p = 1; a_r = $urandom_range(0, 7); a_d = $urandom;
         end
         if (!m_p && ($urandom % 2 == 0)) begin
            m_p = 1; m_r = $urandom_range(0, 7); m_d = $urandom;
         end
         cycle(a_p, a_r, a_d, m_p, m_r, m_d, ($urandom % 3 == 0),
               $urandom_range(0, 7), ga, gm);
         if (ga) a_p = 0;
         if (gm) m_p = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
